// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: accepts a block, steps the external round function and
// key expansion NR times, then holds the ciphertext until taken. Optional macro: AES_ABORT_EN.
module aes_round_ctrl #(
  parameter int unsigned NR = 10,
  parameter int unsigned DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_pt,
  input  logic [DW-1:0] in_key,
  output logic [DW-1:0] rf_state,
  output logic [DW-1:0] rf_key,
  output logic          rf_mix_en,
  input  logic [DW-1:0] rf_out,
  output logic [DW-1:0] ks_key,
  output logic [7:0]    ks_rcon,
  input  logic [DW-1:0] ks_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_ct,
`ifdef AES_ABORT_EN
  input  logic          abort,
`endif
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_DONE
  } fsm_e;

  localparam logic [3:0] NR_L = 4'(NR);

  fsm_e          fsm_q, fsm_d;
  logic [3:0]    round_q, round_d;
  logic [DW-1:0] state_q, state_d;
  logic [DW-1:0] key_q, key_d;
  logic          abort_w;

`ifdef AES_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      round_q <= '0;
      state_q <= '0;
      key_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
      key_q   <= key_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    round_d   = round_q;
    state_d   = state_q;
    key_d     = key_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    ks_rcon   = '0;
    rf_mix_en = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_d = in_pt ^ in_key;
          key_d   = in_key;
          round_d = 4'd1;
          fsm_d   = S_ROUND;
        end
      end
      S_ROUND: begin
        ks_rcon   = rcon(round_q);
        rf_mix_en = (round_q != NR_L);
        if (abort_w) begin
          state_d = '0;
          key_d   = '0;
          round_d = '0;
          fsm_d   = S_IDLE;
        end else begin
          state_d = rf_out;
          key_d   = ks_out;
          // Final round parks the counter at NR instead of advancing it.
          if (round_q == NR_L) fsm_d = S_DONE;
          else round_d = round_q + 4'd1;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (abort_w) begin
          state_d = '0;
          key_d   = '0;
          round_d = '0;
          fsm_d   = S_IDLE;
        end else if (out_ready) begin
          round_d = '0;
          fsm_d   = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  assign rf_state = state_q;
  assign rf_key   = ks_out;
  assign ks_key   = key_q;
  assign out_ct   = state_q;

endmodule
